// File: rtl/zbus_ser_pkg.sv
// zbus_ser_pkg
//   Shared zbus definitions used by the width serializer (and the future
//   deserializer): beat-order constants, serializer state encoding and a
//   counter-width helper that never returns zero.
package zbus_ser_pkg;

  // Beat order: which slice of the wide word leaves first.
  localparam int ORD_LSB = 0;
  localparam int ORD_MSB = 1;

  typedef enum logic {
    ZS_IDLE = 1'b0,
    ZS_BUSY = 1'b1
  } zser_state_e;

  // $clog2 with a floor of 1, so a counter for a single-entry range still
  // has a legal one-bit width.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/zbus_ser.sv
// zbus_ser
//   Width serializer: accepts one BW*SN-bit word per zi transfer and emits it
//   as SN beats of BW bits on the zo side, with zero-bubble streaming of
//   consecutive words.
//
// Ports
//   z_clk    in   clock, all state on rising edge
//   z_rst_n  in   asynchronous reset, active-low
//   zi_vld   in   input word valid
//   zi_bus   in   input wide word (BW*SN)
//   zi_ack   out  input word acknowledge (combinational)
//   zo_vld   out  output beat valid
//   zo_bus   out  output beat data (BW)
//   zo_lst   out  last beat of the current word
//   zo_cnt   out  index of the current beat (SNL)
//   zo_ack   in   output beat acknowledge
//
// state   | meaning
// --------+---------------------------------------------------------------
// ZS_IDLE | no word held, zi_ack high, zo_vld low
// ZS_BUSY | word held in buf_q, beat cnt_q presented on zo_bus
module zbus_ser
  import zbus_ser_pkg::*;
#(
  parameter int BW  = 8,
  parameter int SN  = 4,
  parameter int SNL = clog2_min1(SN),
  parameter int ORD = ORD_LSB
) (
  input  logic             z_clk,
  input  logic             z_rst_n,
  input  logic             zi_vld,
  input  logic [BW*SN-1:0] zi_bus,
  output logic             zi_ack,
  output logic             zo_vld,
  output logic [BW-1:0]    zo_bus,
  output logic             zo_lst,
  output logic [SNL-1:0]   zo_cnt,
  input  logic             zo_ack
);

  localparam logic [SNL-1:0] CNT_LAST = SNL'(SN - 1);

  zser_state_e      state_q, state_d;
  logic [SNL-1:0]   cnt_q, cnt_d;
  logic [BW*SN-1:0] buf_q, buf_d;
  logic             last_beat;
  logic             zi_trn;
  logic             zo_trn;

  assign last_beat = (cnt_q == CNT_LAST);
  assign zo_vld    = (state_q == ZS_BUSY);
  assign zo_trn    = zo_vld & zo_ack;
  // A new word may enter in the same cycle the previous word's last beat
  // leaves, which is what gives gap-free streaming.
  assign zi_ack    = ~zo_vld | (zo_trn & last_beat);
  assign zi_trn    = zi_vld & zi_ack;
  // With a single beat per word the counter always sits on its last value,
  // so lst is held high; consumers qualify it with zo_vld.
  assign zo_lst    = (SN == 1) ? 1'b1 : (zo_vld & last_beat);
  assign zo_cnt    = cnt_q;

  // Slice mux straight off the registered buffer: stable under backpressure.
  always_comb begin
    int sel;
    sel    = (ORD == ORD_MSB) ? (SN - 1 - int'(cnt_q)) : int'(cnt_q);
    zo_bus = '0;
    for (int i = 0; i < SN; i++) begin
      if (sel == i) zo_bus = buf_q[i*BW +: BW];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      ZS_IDLE: begin
        if (zi_trn) begin
          state_d = ZS_BUSY;
          buf_d   = zi_bus;
          cnt_d   = '0;
        end
      end
      ZS_BUSY: begin
        if (zo_trn) begin
          if (!last_beat) begin
            cnt_d = cnt_q + SNL'(1);
          end else begin
            cnt_d = '0;
            if (zi_trn) buf_d = zi_bus;
            else        state_d = ZS_IDLE;
          end
        end
      end
      default: begin
        state_d = ZS_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge z_clk or negedge z_rst_n) begin
    if (!z_rst_n) begin
      state_q <= ZS_IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_zbus_ser.sv
// tb_zbus_ser
//   Three serializer instances: 8x4 LSB-first, 8x4 MSB-first (sharing the
//   same input stimulus) and 16x1. Directed vector table, hand sequences for
//   reset and single-beat streaming, then random traffic against a queue model.
module tb_zbus_ser;

  logic        z_clk;
  logic        z_rst_n;

  logic        zi_vld;
  logic [31:0] zi_bus;
  logic        zo_ack;

  logic        a_zi_ack, a_zo_vld, a_zo_lst;
  logic [7:0]  a_zo_bus;
  logic [1:0]  a_zo_cnt;
  logic        b_zi_ack, b_zo_vld, b_zo_lst;
  logic [7:0]  b_zo_bus;
  logic [1:0]  b_zo_cnt;

  logic        c_zi_vld;
  logic [15:0] c_zi_bus;
  logic        c_zo_ack;
  logic        c_zi_ack, c_zo_vld, c_zo_lst;
  logic [15:0] c_zo_bus;
  logic [0:0]  c_zo_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  zbus_ser #(.BW(8), .SN(4), .ORD(0)) u_lsb (
    .z_clk(z_clk), .z_rst_n(z_rst_n),
    .zi_vld(zi_vld), .zi_bus(zi_bus), .zi_ack(a_zi_ack),
    .zo_vld(a_zo_vld), .zo_bus(a_zo_bus), .zo_lst(a_zo_lst),
    .zo_cnt(a_zo_cnt), .zo_ack(zo_ack)
  );

  zbus_ser #(.BW(8), .SN(4), .ORD(1)) u_msb (
    .z_clk(z_clk), .z_rst_n(z_rst_n),
    .zi_vld(zi_vld), .zi_bus(zi_bus), .zi_ack(b_zi_ack),
    .zo_vld(b_zo_vld), .zo_bus(b_zo_bus), .zo_lst(b_zo_lst),
    .zo_cnt(b_zo_cnt), .zo_ack(zo_ack)
  );

  zbus_ser #(.BW(16), .SN(1)) u_one (
    .z_clk(z_clk), .z_rst_n(z_rst_n),
    .zi_vld(c_zi_vld), .zi_bus(c_zi_bus), .zi_ack(c_zi_ack),
    .zo_vld(c_zo_vld), .zo_bus(c_zo_bus), .zo_lst(c_zo_lst),
    .zo_cnt(c_zo_cnt), .zo_ack(c_zo_ack)
  );

  initial z_clk = 1'b0;
  always #5 z_clk = ~z_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  typedef struct {
    logic        vld;
    logic [31:0] bus;
    logic        ack;
    logic        e_vld;
    logic [7:0]  e_lsb;
    logic [7:0]  e_msb;
    logic [1:0]  e_cnt;
    logic        e_lst;
    logic        e_iack;
  } vec_t;

  function automatic vec_t mk(logic v, logic [31:0] b, logic a, logic ev,
                              logic [7:0] el, logic [7:0] em, logic [1:0] ec,
                              logic elst, logic eia);
    vec_t r;
    r.vld = v; r.bus = b; r.ack = a; r.e_vld = ev; r.e_lsb = el;
    r.e_msb = em; r.e_cnt = ec; r.e_lst = elst; r.e_iack = eia;
    return r;
  endfunction

  // 8x4 check shared by the table and the reset sequence.
  task automatic chk_ab(input string tag, input logic ev, input logic [7:0] el,
                        input logic [7:0] em, input logic [1:0] ec,
                        input logic elst, input logic eia);
    chk({tag, " lsb vld"}, 32'(a_zo_vld), 32'(ev));
    chk({tag, " msb vld"}, 32'(b_zo_vld), 32'(ev));
    chk({tag, " lsb zi_ack"}, 32'(a_zi_ack), 32'(eia));
    chk({tag, " msb zi_ack"}, 32'(b_zi_ack), 32'(eia));
    chk({tag, " lsb lst"}, 32'(a_zo_lst), 32'(elst));
    chk({tag, " msb lst"}, 32'(b_zo_lst), 32'(elst));
    if (ev) begin
      chk({tag, " lsb bus"}, 32'(a_zo_bus), 32'(el));
      chk({tag, " msb bus"}, 32'(b_zo_bus), 32'(em));
      chk({tag, " lsb cnt"}, 32'(a_zo_cnt), 32'(ec));
      chk({tag, " msb cnt"}, 32'(b_zo_cnt), 32'(ec));
    end
  endtask

  vec_t        vt[$];
  logic [7:0]  q_lsb[$];
  logic [7:0]  q_msb[$];
  logic [15:0] q_one[$];

  initial begin
    logic [31:0] w;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [15:0] one_words[3];

    zi_vld = 0; zi_bus = 0; zo_ack = 1;
    c_zi_vld = 0; c_zi_bus = 0; c_zo_ack = 1;
    z_rst_n = 0;

    #2;
    chk_ab("reset", 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1);
    chk("reset lsb cnt", 32'(a_zo_cnt), 32'd0);
    chk("reset lsb bus", 32'(a_zo_bus), 32'd0);
    chk("reset msb bus", 32'(b_zo_bus), 32'd0);
    chk("reset one vld", 32'(c_zo_vld), 32'd0);
    chk("reset one zi_ack", 32'(c_zi_ack), 32'd1);
    chk("reset one bus", 32'(c_zo_bus), 32'd0);
    repeat (2) @(negedge z_clk);
    z_rst_n = 1;

    // ---------------- directed vector table (8x4 instances) --------------
    w  = 32'hA1B2C3D4;
    w0 = 32'h03020100;
    w1 = 32'h07060504;
    // single word
    vt.push_back(mk(1, w, 1, 0, 8'h00, 8'h00, 0, 0, 1));
    vt.push_back(mk(0, 0, 1, 1, 8'hD4, 8'hA1, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 8'hC3, 8'hB2, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 8'hB2, 8'hC3, 2, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 8'hA1, 8'hD4, 3, 1, 1));
    vt.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1));
    // backpressure at beat 1
    vt.push_back(mk(1, w, 1, 0, 8'h00, 8'h00, 0, 0, 1));
    vt.push_back(mk(0, 0, 1, 1, 8'hD4, 8'hA1, 0, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 8'hC3, 8'hB2, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 8'hC3, 8'hB2, 1, 0, 0));
    vt.push_back(mk(0, 0, 0, 1, 8'hC3, 8'hB2, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 8'hC3, 8'hB2, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 8'hB2, 8'hC3, 2, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 8'hA1, 8'hD4, 3, 1, 1));
    vt.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1));
    // back-to-back words, no gap
    vt.push_back(mk(1, w0, 1, 0, 8'h00, 8'h00, 0, 0, 1));
    vt.push_back(mk(1, w1, 1, 1, 8'h00, 8'h03, 0, 0, 0));
    vt.push_back(mk(1, w1, 1, 1, 8'h01, 8'h02, 1, 0, 0));
    vt.push_back(mk(1, w1, 1, 1, 8'h02, 8'h01, 2, 0, 0));
    vt.push_back(mk(1, w1, 1, 1, 8'h03, 8'h00, 3, 1, 1));
    vt.push_back(mk(0, 0, 1, 1, 8'h04, 8'h07, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 8'h05, 8'h06, 1, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 8'h06, 8'h05, 2, 0, 0));
    vt.push_back(mk(0, 0, 1, 1, 8'h07, 8'h04, 3, 1, 1));
    vt.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 0, 1));

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge z_clk);
      zi_vld = vt[i].vld; zi_bus = vt[i].bus; zo_ack = vt[i].ack;
      #1;
      chk_ab($sformatf("vec%0d", i), vt[i].e_vld, vt[i].e_lsb, vt[i].e_msb,
             vt[i].e_cnt, vt[i].e_lst, vt[i].e_iack);
    end

    // ---------------- reset in the middle of a word ----------------------
    @(negedge z_clk);
    zi_vld = 1; zi_bus = w; zo_ack = 1;
    @(negedge z_clk);
    zi_vld = 0; zi_bus = 0;
    @(negedge z_clk);
    @(negedge z_clk);
    #1;
    chk_ab("midrst before", 1'b1, 8'hB2, 8'hC3, 2'd2, 1'b0, 1'b0);
    z_rst_n = 0;
    #1;
    chk_ab("midrst async", 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1);
    chk("midrst lsb cnt", 32'(a_zo_cnt), 32'd0);
    chk("midrst lsb bus", 32'(a_zo_bus), 32'd0);
    chk("midrst msb bus", 32'(b_zo_bus), 32'd0);
    @(negedge z_clk);
    z_rst_n = 1;
    @(negedge z_clk);
    zi_vld = 1; zi_bus = 32'h55667788;
    #1;
    chk_ab("post-rst accept", 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1);
    @(negedge z_clk);
    zi_vld = 0; zi_bus = 0;
    #1;
    chk_ab("post-rst b0", 1'b1, 8'h88, 8'h55, 2'd0, 1'b0, 1'b0);
    @(negedge z_clk); #1;
    chk_ab("post-rst b1", 1'b1, 8'h77, 8'h66, 2'd1, 1'b0, 1'b0);
    @(negedge z_clk); #1;
    chk_ab("post-rst b2", 1'b1, 8'h66, 8'h77, 2'd2, 1'b0, 1'b0);
    @(negedge z_clk); #1;
    chk_ab("post-rst b3", 1'b1, 8'h55, 8'h88, 2'd3, 1'b1, 1'b1);
    @(negedge z_clk); #1;
    chk_ab("post-rst idle", 1'b0, 8'h00, 8'h00, 2'd0, 1'b0, 1'b1);

    // ---------------- SN=1 streaming --------------------------------------
    one_words[0] = 16'h1111; one_words[1] = 16'h2222; one_words[2] = 16'h3333;
    for (int i = 0; i < 5; i++) begin
      @(negedge z_clk);
      c_zo_ack = 1;
      c_zi_vld = (i < 3);
      c_zi_bus = (i < 3) ? one_words[i] : 16'h0;
      #1;
      chk($sformatf("one%0d zi_ack", i), 32'(c_zi_ack), 32'd1);
      chk($sformatf("one%0d vld", i), 32'(c_zo_vld), 32'((i >= 1) && (i <= 3)));
      if ((i >= 1) && (i <= 3)) begin
        chk($sformatf("one%0d bus", i), 32'(c_zo_bus), 32'(one_words[i-1]));
        chk($sformatf("one%0d lst", i), 32'(c_zo_lst), 32'd1);
        chk($sformatf("one%0d cnt", i), 32'(c_zo_cnt), 32'd0);
      end
    end

    // ---------------- random traffic vs. queue model ---------------------
    @(negedge z_clk);
    zi_vld = 0; c_zi_vld = 0;
    z_rst_n = 0;
    @(negedge z_clk);
    z_rst_n = 1;
    q_lsb.delete(); q_msb.delete(); q_one.delete();

    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic e_vld, e_iack, ce_vld, ce_iack;
      @(negedge z_clk);
      zi_vld   = ($urandom_range(0, 2) != 0);
      zi_bus   = $urandom;
      zo_ack   = ($urandom_range(0, 3) != 0);
      c_zi_vld = ($urandom_range(0, 2) != 0);
      c_zi_bus = 16'($urandom);
      c_zo_ack = ($urandom_range(0, 3) != 0);
      #1;
      // A word occupies the serializer until its remaining beats drain;
      // space opens when nothing is left or the final beat is leaving now.
      e_vld  = (q_lsb.size() != 0);
      e_iack = (q_lsb.size() == 0) || ((q_lsb.size() == 1) && zo_ack);
      chk("rnd lsb vld", 32'(a_zo_vld), 32'(e_vld));
      chk("rnd msb vld", 32'(b_zo_vld), 32'(e_vld));
      chk("rnd zi_ack", 32'(a_zi_ack), 32'(e_iack));
      chk("rnd msb zi_ack", 32'(b_zi_ack), 32'(e_iack));
      chk("rnd lsb lst", 32'(a_zo_lst), 32'(q_lsb.size() == 1));
      if (e_vld) begin
        chk("rnd lsb bus", 32'(a_zo_bus), 32'(q_lsb[0]));
        chk("rnd msb bus", 32'(b_zo_bus), 32'(q_msb[0]));
        chk("rnd lsb cnt", 32'(a_zo_cnt), 32'(4 - q_lsb.size()));
      end
      ce_vld  = (q_one.size() != 0);
      ce_iack = (q_one.size() == 0) || c_zo_ack;
      chk("rnd one vld", 32'(c_zo_vld), 32'(ce_vld));
      chk("rnd one zi_ack", 32'(c_zi_ack), 32'(ce_iack));
      if (ce_vld) begin
        chk("rnd one bus", 32'(c_zo_bus), 32'(q_one[0]));
        chk("rnd one lst", 32'(c_zo_lst), 32'd1);
      end

      if (e_vld && zo_ack) begin
        void'(q_lsb.pop_front());
        void'(q_msb.pop_front());
      end
      if (zi_vld && e_iack) begin
        for (int k = 0; k < 4; k++) begin
          q_lsb.push_back(zi_bus[8*k +: 8]);
          q_msb.push_back(zi_bus[8*(3-k) +: 8]);
        end
      end
      if (ce_vld && c_zo_ack) void'(q_one.pop_front());
      if (c_zi_vld && ce_iack) q_one.push_back(c_zi_bus);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
